// File: rtl/atomic_alu_arbiter.sv
// Round-robin arbiter sharing one atomic ALU controller among NUM_REQ requesters.
// Optional macro CAS_PRIORITY_EN: pending CAS commands (op 3'b111) win over all other ops.
module atomic_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*12-1:0] cmd_in,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  syscall,
  output logic [11:0]           command,
  input  logic [31:0]           alu_y,
  input  logic                  alu_o,
  input  logic                  alu_c,
  input  logic                  alu_z,
  input  logic                  alu_n,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_y,
  output logic [3:0]            resp_flags,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_id;
  logic [ID_W-1:0]     win_id;
  logic [3:0]          wait_cnt;
  logic [NUM_REQ-1:0]  cand;
  logic [11:0]         win_cmd;

  // First candidate at or after ptr, wrapping; later offsets are overwritten by nearer ones.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (c[idx]) pick = idx;
    end
    return pick;
  endfunction

`ifdef CAS_PRIORITY_EN
  logic [NUM_REQ-1:0] cas_vec;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cas
    assign cas_vec[g] = req[g] && (cmd_in[12*g+9 +: 3] == 3'b111);
  end
  assign cand = (|cas_vec) ? cas_vec : req;
`else
  assign cand = req;
`endif

  assign win_id = rr_pick(cand, rr_ptr);

  // Mux only the winning lane so X on idle lanes cannot leak into command.
  always_comb begin
    win_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) win_cmd = cmd_in[12*i +: 12];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      wait_cnt   <= '0;
      ack        <= '0;
      syscall    <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      command    <= '0;
      resp_id    <= '0;
      resp_y     <= '0;
      resp_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            command <= win_cmd;
            cur_id  <= win_id;
            ack     <= NUM_REQ'(1) << win_id;
            syscall <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          ack      <= '0;
          syscall  <= 1'b0;
          rr_ptr   <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
          wait_cnt <= 4'(ALU_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            resp_y     <= alu_y;
            resp_flags <= {alu_o, alu_c, alu_z, alu_n};
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atomic_alu_arbiter.sv
// Directed testbench for atomic_alu_arbiter (NUM_REQ=4, ALU_LAT=2).
module tb_atomic_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ALU_LAT = 2;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*12-1:0] cmd_in = '0;
  logic [NUM_REQ-1:0]    ack;
  logic                  syscall;
  logic [11:0]           command;
  logic [31:0]           alu_y = '0;
  logic                  alu_o = 1'b0;
  logic                  alu_c = 1'b0;
  logic                  alu_z = 1'b0;
  logic                  alu_n = 1'b0;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_y;
  logic [3:0]            resp_flags;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sc_cnt = 0;
  int rv_cnt = 0;
  int ack1_cnt = 0;

  atomic_alu_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in), .ack(ack),
    .syscall(syscall), .command(command), .alu_y(alu_y),
    .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
    .resp_flags(resp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (syscall === 1'b1) sc_cnt <= sc_cnt + 1;
    if (resp_valid === 1'b1) rv_cnt <= rv_cnt + 1;
    if (ack[1] === 1'b1) ack1_cnt <= ack1_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output logic [3:0] a);
    int n;
    n = 0;
    while (ack === 4'b0 && n < 20) begin
      step();
      n++;
    end
    a = ack;
    chk("ack_timeout", {31'b0, ack !== 4'b0}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] lc [4];
    logic [3:0]  a;
    int          last;
    int          exp_id;
    int          sc0;
    int          rv0;
    int          ak0;

    lc[0] = 12'h053;
    lc[1] = 12'h2A1;
    lc[2] = 12'h4C2;
    lc[3] = 12'h6E3;
    for (int i = 0; i < 4; i++) cmd_in[i*12 +: 12] = lc[i];

    // Reset state
    step();
    step();
    chk("rst_ack", {28'b0, ack}, 32'd0);
    chk("rst_syscall", {31'b0, syscall}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_command", {20'b0, command}, 32'd0);
    chk("rst_resp_id", {30'b0, resp_id}, 32'd0);
    chk("rst_resp_y", resp_y, 32'd0);
    chk("rst_resp_flags", {28'b0, resp_flags}, 32'd0);
    rst = 1'b0;

    // Test 1: single request, full latency path
    alu_y = 32'hDEAD_BEEF;
    alu_z = 1'b1;
    req = 4'b0001;
    step();
    chk("t1_ack", {28'b0, ack}, 32'h1);
    chk("t1_syscall", {31'b0, syscall}, 32'd1);
    chk("t1_command", {20'b0, command}, 32'h053);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    req = 4'b0000;
    step();
    chk("t1_ack_drop", {28'b0, ack}, 32'd0);
    chk("t1_syscall_drop", {31'b0, syscall}, 32'd0);
    step();
    chk("t1_no_early_resp", {31'b0, resp_valid}, 32'd0);
    step();
    chk("t1_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("t1_resp_id", {30'b0, resp_id}, 32'd0);
    chk("t1_resp_y", resp_y, 32'hDEAD_BEEF);
    chk("t1_resp_flags", {28'b0, resp_flags}, 32'h2);
    step();
    chk("t1_resp_done", {31'b0, resp_valid}, 32'd0);
    chk("t1_idle", {31'b0, busy}, 32'd0);
    chk("t1_resp_y_hold", resp_y, 32'hDEAD_BEEF);
    chk("t1_cmd_hold", {20'b0, command}, 32'h053);

    // Test 2: all lanes requesting, round-robin order and spacing
    do_reset();
    req = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      wait_ack(a);
      chk("t2_ack", {28'b0, a}, 32'(1) << exp_id);
      chk("t2_syscall", {31'b0, syscall}, 32'd1);
      chk("t2_command", {20'b0, command}, {20'b0, lc[exp_id]});
      if (g > 0) chk("t2_spacing", 32'(cyc - last), 32'd5);
      last = cyc;
      if (g == 4) req = 4'b0000;
      step();
      chk("t2_ack_one_cycle", {28'b0, ack}, 32'd0);
    end
    wait_idle();

    // Test 3: move rr_ptr to 3, then wrap, then sole requester re-granted
    req = 4'b0100;
    wait_ack(a);
    chk("t3_setup_grant2", {28'b0, a}, 32'h4);
    req = 4'b0000;
    wait_idle();
    req = 4'b1001;
    wait_ack(a);
    chk("t3_grant3", {28'b0, a}, 32'h8);
    step();
    wait_ack(a);
    chk("t3_wrap_grant0", {28'b0, a}, 32'h1);
    req = 4'b1000;
    step();
    wait_ack(a);
    chk("t3_sole_grant3_a", {28'b0, a}, 32'h8);
    step();
    wait_ack(a);
    chk("t3_sole_grant3_b", {28'b0, a}, 32'h8);
    req = 4'b0000;
    wait_idle();

    // Test 4: asynchronous reset during WAIT drops the operation
    do_reset();
    alu_y = 32'h1234_5678;
    alu_o = 1'b1;
    alu_z = 1'b0;
    alu_n = 1'b1;
    req = 4'b0100;
    wait_ack(a);
    chk("t4_grant2", {28'b0, a}, 32'h4);
    req = 4'b0000;
    step();
    chk("t4_in_wait", {31'b0, busy}, 32'd1);
    rv0 = rv_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("t4_async_busy", {31'b0, busy}, 32'd0);
    chk("t4_async_command", {20'b0, command}, 32'd0);
    chk("t4_async_ack", {28'b0, ack}, 32'd0);
    chk("t4_async_syscall", {31'b0, syscall}, 32'd0);
    chk("t4_async_resp_valid", {31'b0, resp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t4_no_resp", 32'(rv_cnt - rv0), 32'd0);
    req = 4'b0100;
    wait_ack(a);
    chk("t4_regrant2", {28'b0, a}, 32'h4);
    req = 4'b0000;
    step();
    step();
    step();
    chk("t4_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("t4_resp_id", {30'b0, resp_id}, 32'd2);
    chk("t4_resp_y", resp_y, 32'h1234_5678);
    chk("t4_resp_flags", {28'b0, resp_flags}, 32'h9);
    wait_idle();

    // Test 5: request pulse on lane 1 while busy is ignored
    sc0 = sc_cnt;
    ak0 = ack1_cnt;
    req = 4'b0001;
    wait_ack(a);
    chk("t5_grant0", {28'b0, a}, 32'h1);
    req = 4'b0000;
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    for (int i = 0; i < 5; i++) step();
    chk("t5_no_ack1", 32'(ack1_cnt - ak0), 32'd0);
    chk("t5_one_syscall", 32'(sc_cnt - sc0), 32'd1);
    chk("t5_idle", {31'b0, busy}, 32'd0);

    // Test 6: CAS lane vs plain lane from rr_ptr=0, X on an idle lane
    do_reset();
    cmd_in[0*12 +: 12] = 12'h253;
    cmd_in[1*12 +: 12] = 12'hE51;
    cmd_in[2*12 +: 12] = 12'h000;
    cmd_in[3*12 +: 12] = 12'hxxx;
    req = 4'b0011;
    wait_ack(a);
`ifdef CAS_PRIORITY_EN
    chk("t6_first", {28'b0, a}, 32'h2);
    chk("t6_first_cmd", {20'b0, command}, 32'hE51);
`else
    chk("t6_first", {28'b0, a}, 32'h1);
    chk("t6_first_cmd", {20'b0, command}, 32'h253);
`endif
    req = req & ~a;
    step();
    wait_ack(a);
`ifdef CAS_PRIORITY_EN
    chk("t6_second", {28'b0, a}, 32'h1);
    chk("t6_second_cmd", {20'b0, command}, 32'h253);
`else
    chk("t6_second", {28'b0, a}, 32'h2);
    chk("t6_second_cmd", {20'b0, command}, 32'hE51);
`endif
    req = 4'b0000;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
